ppi_hs_core: RTL and testbench

Clocked, width-parametrised successor to the combinational PPI port/mode block. It implements an 8255-style programmable peripheral interface with a mode-set/bit-set-reset control register, Mode 0 (basic I/O) on all ports, and Mode 1 (strobed handshake I/O with interrupts) on ports A and B. It sits between the CPU bus and three external ports: PA, PB and PC. Handshake lines occupy PC pins.

---
 rtl/ppi_pkg.sv | 12 +
 rtl/ppi_hs_port.sv | 70 +++++++
 rtl/ppi_hs_core.sv | 137 +++++++++++++
 tb/tb_ppi_hs_core.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared constants for the PPI core (addresses, control-word fields, PC pin map)
package ppi_pkg;
  localparam logic [1:0] A_PA = 2'd0, A_PB = 2'd1, A_PC = 2'd2, A_CTL = 2'd3;
  localparam int CW_MSET = 7, CW_MODE_A_HI = 6, CW_MODE_A_LO = 5, CW_PA_DIR = 4;
  localparam int CW_PCU_DIR = 3, CW_MODE_B = 2, CW_PB_DIR = 1, CW_PCL_DIR = 0;
  localparam logic [1:0] MODE_A0 = 2'b00;
  localparam logic MODE_B0 = 1'b0;
  localparam int PC_OBF_A = 7, PC_ACK_A = 6, PC_IBF_A = 5, PC_STB_A = 4, PC_INTR_A = 3;
  localparam int PC_HS_B = 2, PC_BF_B = 1, PC_INTR_B = 0;
  localparam logic [7:0] CTRL_RST = 8'h9B;
  typedef enum logic {HS_IDLE, HS_FULL} hs_st_e;
endpackage

// File: rtl/ppi_hs_port.sv
// ppi_hs_port: one strobed-handshake port (data latch, buffer-full FSM, interrupt and enable flags)
module ppi_hs_port import ppi_pkg::*; #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          m1,
  input  logic          dir_in,
  input  logic          wr,
  input  logic          rd_start,
  input  logic          rd_end,
  input  logic [DW-1:0] d_in,
  input  logic [DW-1:0] pin,
  input  logic          hs_n,
  input  logic          hs_prev,
  input  logic          inte_we,
  input  logic          inte_val,
  output logic [DW-1:0] lat,
  output logic          ibf,
  output logic          obf,
  output logic          intr,
  output logic          inte
);
  hs_st_e st_q, st_d;
  logic intr_q, intr_d, inte_q, inte_d, arm_q, arm_d;
  logic [DW-1:0] lat_q, lat_d;
  logic in_m, out_m, fall, rise;
  assign in_m  = m1 & dir_in;
  assign out_m = m1 & ~dir_in;
  assign fall  = hs_prev & ~hs_n;
  assign rise  = ~hs_prev & hs_n;
  // buffer-full state register; a mode-set aborts like reset
  always_ff @(posedge clk)
    if (rst || clr) st_q <= HS_IDLE;
    else st_q <= st_d;
  // input fills on strobe fall and empties when the read that saw it ends; output fills on write, empties on ack fall
  always_comb
    st_d = in_m ? (fall ? HS_FULL : (rd_end && arm_q) ? HS_IDLE : st_q) :
           out_m ? (wr ? HS_FULL : fall ? HS_IDLE : st_q) : HS_IDLE;
  // buffer-full status towards the PC pins
  always_comb begin
    ibf = in_m && st_q == HS_FULL;
    obf = out_m && st_q == HS_FULL;
  end
  // interrupt, enable, latch; arm marks a read that started on already-latched data
  always_comb begin
    intr_d = in_m ? (rd_start ? 1'b0 : (rise && ibf && inte_q) ? 1'b1 : intr_q) :
             out_m ? (wr ? 1'b0 : (rise && inte_q) ? 1'b1 : intr_q) : 1'b0;
    inte_d = inte_we ? inte_val : inte_q;
    arm_d  = rd_start ? ~fall : (fall || rd_end) ? 1'b0 : arm_q;
    lat_d  = (in_m && fall) ? pin : (wr && !in_m) ? d_in : lat_q;
  end
  // flag and latch registers
  always_ff @(posedge clk)
    if (rst || clr) begin
      intr_q <= 1'b0;
      inte_q <= 1'b0;
      arm_q  <= 1'b0;
      lat_q  <= '0;
    end else begin
      intr_q <= intr_d;
      inte_q <= inte_d;
      arm_q  <= arm_d;
      lat_q  <= lat_d;
    end
  assign lat  = lat_q;
  assign intr = intr_q;
  assign inte = inte_q;
endmodule

// File: rtl/ppi_hs_core.sv
// ppi_hs_core: clocked 8255-style PPI with Mode 0 on all ports and Mode 1 handshake on A and B
module ppi_hs_core import ppi_pkg::*; #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    a,
  input  logic          cs,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  output logic          d_oe,
  input  logic [DW-1:0] pa_in,
  output logic [DW-1:0] pa_out,
  output logic          pa_oe,
  input  logic [DW-1:0] pb_in,
  output logic [DW-1:0] pb_out,
  output logic          pb_oe,
  input  logic [7:0]    pc_in,
  output logic [7:0]    pc_out,
  output logic [7:0]    pc_oe,
  output logic          intr_a,
  output logic          intr_b
);
  logic [7:0] ctrl_q, ctrl_d, pcl_q, pcl_d, pcs_q, own, hs_val, hs_oe, pc_dir, pc_rd;
  logic [DW-1:0] d_out_q, d_out_d, rd_mux, lat_a, lat_b;
  logic [1:0] ra_q;
  logic [2:0] bit_idx;
  logic rdl_q, wrl_q, d_oe_q, rd_lvl, wr_lvl, rd_st, wr_st, rd_end, mset, bsr;
  logic ma, mb, a_in, a_out, we_a, we_b, hs_a, hp_a;
  logic ibf_a, obf_a, int_a, inte_a, ibf_b, obf_b, int_b, inte_b;
  // bus edge detection, control decode and handshake pin selection
  always_comb begin
    rd_lvl  = cs & rd & ~wr;
    wr_lvl  = cs & wr & ~rd;
    rd_st   = rd_lvl & ~rdl_q;
    wr_st   = wr_lvl & ~wrl_q;
    rd_end  = rdl_q & ~rd_lvl;
    mset    = wr_st && a == A_CTL && d_in[CW_MSET];
    bsr     = wr_st && a == A_CTL && !d_in[CW_MSET];
    bit_idx = d_in[3:1];
    ma      = ctrl_q[CW_MODE_A_HI:CW_MODE_A_LO] != MODE_A0;
    mb      = ctrl_q[CW_MODE_B] != MODE_B0;
    a_in    = ma & ctrl_q[CW_PA_DIR];
    a_out   = ma & ~ctrl_q[CW_PA_DIR];
    we_a    = bsr && ((a_in && bit_idx == 3'(PC_STB_A)) || (a_out && bit_idx == 3'(PC_ACK_A)));
    we_b    = bsr && mb && bit_idx == 3'(PC_HS_B);
    hs_a    = a_out ? pc_in[PC_ACK_A] : pc_in[PC_STB_A];
    hp_a    = a_out ? pcs_q[PC_ACK_A] : pcs_q[PC_STB_A];
    ctrl_d  = mset ? d_in[7:0] : ctrl_q;
  end
  // PC pin map: handshake-owned pins carry status, the rest behave as Mode 0 bits
  always_comb begin
    own = '0;
    own[PC_OBF_A] = a_out;
    own[PC_ACK_A] = a_out;
    own[PC_IBF_A] = a_in;
    own[PC_STB_A] = a_in;
    own[PC_INTR_A] = ma;
    own[PC_HS_B] = mb;
    own[PC_BF_B] = mb;
    own[PC_INTR_B] = mb;
    hs_val = '0;
    hs_val[PC_OBF_A] = ~obf_a;
    hs_val[PC_ACK_A] = inte_a;
    hs_val[PC_IBF_A] = ibf_a;
    hs_val[PC_STB_A] = inte_a;
    hs_val[PC_INTR_A] = int_a;
    hs_val[PC_HS_B] = inte_b;
    hs_val[PC_BF_B] = ctrl_q[CW_PB_DIR] ? ibf_b : ~obf_b;
    hs_val[PC_INTR_B] = int_b;
    hs_oe = '1;
    hs_oe[PC_ACK_A] = 1'b0;
    hs_oe[PC_STB_A] = 1'b0;
    hs_oe[PC_HS_B] = 1'b0;
    pc_dir = {{4{ctrl_q[CW_PCU_DIR]}}, {4{ctrl_q[CW_PCL_DIR]}}};
    pc_out = (own & hs_val) | (~own & pcl_q);
    pc_oe  = (own & hs_oe) | (~own & ~pc_dir);
    pc_rd  = (own & hs_val) | (~own & ((pc_dir & pc_in) | (~pc_dir & pcl_q)));
  end
  // PC output latch: whole-byte writes, BSR on non-handshake pins, cleared by mode-set
  always_comb begin
    pcl_d = pcl_q;
    if (bsr && !own[bit_idx]) pcl_d[bit_idx] = d_in[0];
    if (wr_st && a == A_PC) pcl_d = d_in[7:0];
    if (mset) pcl_d = '0;
  end
  // read data captured at the start of an access
  always_comb begin
    rd_mux = a == A_PA ? ((ctrl_q[CW_PA_DIR] && !ma) ? pa_in : lat_a) :
             a == A_PB ? ((ctrl_q[CW_PB_DIR] && !mb) ? pb_in : lat_b) :
             a == A_PC ? DW'(pc_rd) : DW'(ctrl_q);
    d_out_d = rd_st ? rd_mux : d_out_q;
  end
  // control, PC latch, pin history and bus registers
  always_ff @(posedge clk)
    if (rst) begin
      ctrl_q  <= CTRL_RST;
      pcl_q   <= '0;
      pcs_q   <= '0;
      rdl_q   <= 1'b0;
      wrl_q   <= 1'b0;
      ra_q    <= A_PA;
      d_out_q <= '0;
      d_oe_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      pcl_q   <= pcl_d;
      pcs_q   <= pc_in;
      rdl_q   <= rd_lvl;
      wrl_q   <= wr_lvl;
      ra_q    <= rd_st ? a : ra_q;
      d_out_q <= d_out_d;
      d_oe_q  <= rd_lvl;
    end
  ppi_hs_port #(.DW(DW)) u_a (
    .clk, .rst, .clr(mset), .m1(ma), .dir_in(ctrl_q[CW_PA_DIR]),
    .wr(wr_st && a == A_PA), .rd_start(rd_st && a == A_PA), .rd_end(rd_end && ra_q == A_PA),
    .d_in, .pin(pa_in), .hs_n(hs_a), .hs_prev(hp_a), .inte_we(we_a), .inte_val(d_in[0]),
    .lat(lat_a), .ibf(ibf_a), .obf(obf_a), .intr(int_a), .inte(inte_a)
  );
  ppi_hs_port #(.DW(DW)) u_b (
    .clk, .rst, .clr(mset), .m1(mb), .dir_in(ctrl_q[CW_PB_DIR]),
    .wr(wr_st && a == A_PB), .rd_start(rd_st && a == A_PB), .rd_end(rd_end && ra_q == A_PB),
    .d_in, .pin(pb_in), .hs_n(pc_in[PC_HS_B]), .hs_prev(pcs_q[PC_HS_B]), .inte_we(we_b), .inte_val(d_in[0]),
    .lat(lat_b), .ibf(ibf_b), .obf(obf_b), .intr(int_b), .inte(inte_b)
  );
  assign d_out  = d_out_q;
  assign d_oe   = d_oe_q;
  assign pa_out = lat_a;
  assign pb_out = lat_b;
  assign pa_oe  = ~ctrl_q[CW_PA_DIR];
  assign pb_oe  = ~ctrl_q[CW_PB_DIR];
  assign intr_a = int_a;
  assign intr_b = int_b;
endmodule

// File: tb/tb_ppi_hs_core.sv
// tb_ppi_hs_core: randomized self-checking bench for the PPI core against a rule-level model
module tb_ppi_hs_core;
  localparam int DW = 8;
  logic clk = 1'b0, rst = 1'b1, cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0] a = 2'd0;
  logic [DW-1:0] d_in = '0, d_out, pa_in = '0, pa_out, pb_in = '0, pb_out;
  logic d_oe, pa_oe, pb_oe, intr_a, intr_b;
  logic [7:0] pc_in = 8'hFF, pc_out, pc_oe;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ppi_hs_core #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .a(a), .cs(cs), .rd(rd), .wr(wr),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
    .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe),
    .pc_in(pc_in), .pc_out(pc_out), .pc_oe(pc_oe),
    .intr_a(intr_a), .intr_b(intr_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] ad, input logic [7:0] v);
    a = ad; d_in = DW'(v); cs = 1; wr = 1;
    cyc();
    cs = 0; wr = 0;
    cyc();
  endtask

  task automatic bus_rd(input logic [1:0] ad, output logic [DW-1:0] v);
    a = ad; cs = 1; rd = 1;
    cyc();
    v = d_out;
    cs = 0; rd = 0;
    cyc();
  endtask

  task automatic test_reset();
    logic [DW-1:0] v, pb;
    rst = 1;
    repeat (3) cyc();
    if (d_out !== '0) begin bad++; $display("FAIL rst_d_out got %h want 0", d_out); end total++;
    if (d_oe !== 1'b0) begin bad++; $display("FAIL rst_d_oe got %b want 0", d_oe); end total++;
    if ({pa_oe, pb_oe} !== 2'b00) begin bad++; $display("FAIL rst_port_oe got %b want 00", {pa_oe, pb_oe}); end total++;
    if (pc_oe !== 8'h00) begin bad++; $display("FAIL rst_pc_oe got %h want 00", pc_oe); end total++;
    if (pc_out !== 8'h00) begin bad++; $display("FAIL rst_pc_out got %h want 00", pc_out); end total++;
    if ({intr_a, intr_b} !== 2'b00) begin bad++; $display("FAIL rst_intr got %b want 00", {intr_a, intr_b}); end total++;
    rst = 0;
    pa_in = 8'h5A; pb = DW'($urandom); pb_in = pb;
    a = 2'd0; cs = 1; rd = 1;
    cyc();
    if (d_oe !== 1'b1) begin bad++; $display("FAIL rd_d_oe got %b want 1", d_oe); end total++;
    if (d_out !== 8'h5A) begin bad++; $display("FAIL rst_rd_pa got %h want 5a", d_out); end total++;
    cs = 0; rd = 0;
    cyc();
    if (d_oe !== 1'b0) begin bad++; $display("FAIL rd_d_oe_off got %b want 0", d_oe); end total++;
    bus_rd(2'd1, v);
    if (v !== pb) begin bad++; $display("FAIL rst_rd_pb got %h want %h", v, pb); end total++;
    bus_rd(2'd3, v);
    if (v !== 8'h9B) begin bad++; $display("FAIL rst_rd_ctrl got %h want 9b", v); end total++;
    bus_rd(2'd2, v);
    if (v !== 8'hFF) begin bad++; $display("FAIL rst_rd_pc got %h want ff", v); end total++;
  endtask

  task automatic test_mode0();
    logic [DW-1:0] v;
    bus_wr(2'd3, 8'h80);
    a = 2'd0; d_in = 8'hC3; cs = 1; wr = 1;
    cyc();
    if (pa_out !== 8'hC3) begin bad++; $display("FAIL m0_pa_out got %h want c3", pa_out); end total++;
    if (pa_oe !== 1'b1) begin bad++; $display("FAIL m0_pa_oe got %b want 1", pa_oe); end total++;
    cs = 0; wr = 0;
    cyc();
    bus_wr(2'd3, 8'h0F);
    if (pc_out !== 8'h80) begin bad++; $display("FAIL m0_bsr_pc7 got %h want 80", pc_out); end total++;
    if (pc_oe !== 8'hFF) begin bad++; $display("FAIL m0_pc_oe got %h want ff", pc_oe); end total++;
    pa_in = 8'h11;
    bus_rd(2'd0, v);
    if (v !== 8'hC3) begin bad++; $display("FAIL m0_rd_out_latch got %h want c3", v); end total++;
  endtask

  task automatic test_mode0_random();
    logic [7:0] c, m_pc, msk, wc;
    logic [DW-1:0] m_pa, m_pb, v;
    logic [2:0] bi;
    logic bv;
    for (int it = 0; it < 16; it++) begin
      c = 8'h80 | (8'($urandom) & 8'h1B);
      bus_wr(2'd3, c);
      m_pa = DW'($urandom); m_pb = DW'($urandom); wc = 8'($urandom);
      bus_wr(2'd0, m_pa);
      bus_wr(2'd1, m_pb);
      bus_wr(2'd2, wc);
      m_pc = wc;
      bi = 3'($urandom_range(0, 7)); bv = 1'($urandom);
      bus_wr(2'd3, {4'b0, bi, bv});
      m_pc[bi] = bv;
      pa_in = DW'($urandom); pb_in = DW'($urandom); pc_in = 8'($urandom);
      msk = {{4{c[3]}}, {4{c[0]}}};
      if (pa_out !== m_pa || pa_oe !== ~c[4]) begin bad++; $display("FAIL rnd_pa_drive got %h/%b want %h/%b", pa_out, pa_oe, m_pa, ~c[4]); end total++;
      if (pb_out !== m_pb || pb_oe !== ~c[1]) begin bad++; $display("FAIL rnd_pb_drive got %h/%b want %h/%b", pb_out, pb_oe, m_pb, ~c[1]); end total++;
      if (pc_out !== m_pc || pc_oe !== ~msk) begin bad++; $display("FAIL rnd_pc_drive got %h/%h want %h/%h", pc_out, pc_oe, m_pc, ~msk); end total++;
      bus_rd(2'd0, v);
      if (v !== (c[4] ? pa_in : m_pa)) begin bad++; $display("FAIL rnd_rd_pa got %h want %h", v, c[4] ? pa_in : m_pa); end total++;
      bus_rd(2'd1, v);
      if (v !== (c[1] ? pb_in : m_pb)) begin bad++; $display("FAIL rnd_rd_pb got %h want %h", v, c[1] ? pb_in : m_pb); end total++;
      bus_rd(2'd2, v);
      if (v !== DW'((pc_in & msk) | (m_pc & ~msk))) begin bad++; $display("FAIL rnd_rd_pc got %h want %h", v, (pc_in & msk) | (m_pc & ~msk)); end total++;
      bus_rd(2'd3, v);
      if (v !== DW'(c)) begin bad++; $display("FAIL rnd_rd_ctrl got %h want %h", v, c); end total++;
    end
    pc_in = 8'hFF;
    cyc();
  endtask

  task automatic test_a_in();
    logic [DW-1:0] v, dv;
    logic ie;
    bus_wr(2'd3, 8'hB0);
    bus_wr(2'd3, 8'h09);
    pa_in = 8'h3C; pc_in[4] = 0;
    cyc();
    if (pc_out[5] !== 1'b1) begin bad++; $display("FAIL ain_ibf_set got %b want 1", pc_out[5]); end total++;
    if (intr_a !== 1'b0) begin bad++; $display("FAIL ain_intr_early got %b want 0", intr_a); end total++;
    pa_in = 8'hA5; pc_in[4] = 1;
    cyc();
    if (intr_a !== 1'b1) begin bad++; $display("FAIL ain_intr_rise got %b want 1", intr_a); end total++;
    if (pc_oe !== 8'hEF) begin bad++; $display("FAIL ain_pc_oe got %h want ef", pc_oe); end total++;
    bus_rd(2'd2, v);
    if (v !== 8'h38) begin bad++; $display("FAIL ain_pc_status got %h want 38", v); end total++;
    a = 2'd0; cs = 1; rd = 1;
    cyc();
    if (d_out !== 8'h3C) begin bad++; $display("FAIL ain_rd_data got %h want 3c", d_out); end total++;
    if (intr_a !== 1'b0 || pc_out[5] !== 1'b1) begin bad++; $display("FAIL ain_rd_start got intr=%b ibf=%b want 0/1", intr_a, pc_out[5]); end total++;
    cs = 0; rd = 0;
    cyc();
    if (pc_out[5] !== 1'b0) begin bad++; $display("FAIL ain_ibf_clear got %b want 0", pc_out[5]); end total++;
    for (int it = 0; it < 6; it++) begin
      ie = 1'($urandom);
      bus_wr(2'd3, {4'b0, 3'd4, ie});
      dv = DW'($urandom);
      pa_in = dv; pc_in[4] = 0;
      cyc();
      pa_in = ~dv; pc_in[4] = 1;
      cyc();
      if (intr_a !== ie || pc_out[5] !== 1'b1) begin bad++; $display("FAIL ain_rnd_flags got intr=%b ibf=%b want %b/1", intr_a, pc_out[5], ie); end total++;
      bus_rd(2'd0, v);
      if (v !== dv || pc_out[5] !== 1'b0) begin bad++; $display("FAIL ain_rnd_read got %h ibf=%b want %h/0", v, pc_out[5], dv); end total++;
    end
  endtask

  task automatic test_a_out();
    logic [DW-1:0] v, dv;
    bus_wr(2'd3, 8'hA0);
    if (pc_out[7] !== 1'b1 || pa_oe !== 1'b1) begin bad++; $display("FAIL aout_idle got obf_n=%b oe=%b want 1/1", pc_out[7], pa_oe); end total++;
    bus_wr(2'd3, 8'h0D);
    a = 2'd0; d_in = 8'h77; cs = 1; wr = 1;
    cyc();
    if (pc_out[7] !== 1'b0 || pa_out !== 8'h77) begin bad++; $display("FAIL aout_write got obf_n=%b pa=%h want 0/77", pc_out[7], pa_out); end total++;
    cs = 0; wr = 0; pc_in[6] = 0;
    cyc();
    if (pc_out[7] !== 1'b1 || intr_a !== 1'b0) begin bad++; $display("FAIL aout_ack_fall got obf_n=%b intr=%b want 1/0", pc_out[7], intr_a); end total++;
    pc_in[6] = 1;
    cyc();
    if (intr_a !== 1'b1) begin bad++; $display("FAIL aout_ack_rise got %b want 1", intr_a); end total++;
    bus_rd(2'd2, v);
    if (v !== 8'hC8) begin bad++; $display("FAIL aout_pc_status got %h want c8", v); end total++;
    dv = DW'($urandom);
    a = 2'd0; d_in = dv; cs = 1; wr = 1; pc_in[6] = 0;
    cyc();
    if (pc_out[7] !== 1'b0 || intr_a !== 1'b0) begin bad++; $display("FAIL aout_collide got obf_n=%b intr=%b want 0/0", pc_out[7], intr_a); end total++;
    cs = 0; wr = 0; pc_in[6] = 1;
    cyc();
    if (pc_out[7] !== 1'b0 || intr_a !== 1'b1 || pa_out !== dv) begin bad++; $display("FAIL aout_collide_rise got obf_n=%b intr=%b pa=%h want 0/1/%h", pc_out[7], intr_a, pa_out, dv); end total++;
  endtask

  task automatic test_b_collide();
    logic [DW-1:0] v, v1, v2;
    bus_wr(2'd3, 8'h86);
    v1 = DW'($urandom); v2 = ~v1;
    pb_in = v1; pc_in[2] = 0;
    cyc();
    if (pc_out[1] !== 1'b1) begin bad++; $display("FAIL bin_ibf_set got %b want 1", pc_out[1]); end total++;
    pc_in[2] = 1;
    cyc();
    bus_rd(2'd1, v);
    if (v !== v1 || pc_out[1] !== 1'b0) begin bad++; $display("FAIL bin_read got %h ibf=%b want %h/0", v, pc_out[1], v1); end total++;
    pb_in = v2; a = 2'd1; cs = 1; rd = 1; pc_in[2] = 0;
    cyc();
    if (d_out !== v1 || pc_out[1] !== 1'b1) begin bad++; $display("FAIL bin_collide got %h ibf=%b want %h/1", d_out, pc_out[1], v1); end total++;
    cs = 0; rd = 0; pc_in[2] = 1;
    cyc();
    if (pc_out[1] !== 1'b1 || intr_b !== 1'b0) begin bad++; $display("FAIL bin_collide_end got ibf=%b intr=%b want 1/0", pc_out[1], intr_b); end total++;
    bus_rd(2'd1, v);
    if (v !== v2 || pc_out[1] !== 1'b0) begin bad++; $display("FAIL bin_reread got %h ibf=%b want %h/0", v, pc_out[1], v2); end total++;
  endtask

  task automatic test_rst_mid();
    logic [DW-1:0] v;
    bus_wr(2'd3, 8'hB0);
    bus_wr(2'd3, 8'h09);
    bus_wr(2'd1, 8'($urandom_range(1, 255)));
    bus_wr(2'd3, 8'h0F);
    pa_in = DW'($urandom); pc_in[4] = 0;
    cyc();
    pc_in[4] = 1;
    cyc();
    if (intr_a !== 1'b1 || pc_out[5] !== 1'b1) begin bad++; $display("FAIL mid_setup got intr=%b ibf=%b want 1/1", intr_a, pc_out[5]); end total++;
    rst = 1;
    cyc();
    if (intr_a !== 1'b0 || intr_b !== 1'b0) begin bad++; $display("FAIL mid_rst_intr got %b%b want 00", intr_a, intr_b); end total++;
    if (pc_out !== 8'h00 || pc_oe !== 8'h00) begin bad++; $display("FAIL mid_rst_pc got %h/%h want 00/00", pc_out, pc_oe); end total++;
    if (pa_oe !== 1'b0 || pb_oe !== 1'b0 || pa_out !== '0 || pb_out !== '0) begin bad++; $display("FAIL mid_rst_ports got %b%b %h %h want 00 0 0", pa_oe, pb_oe, pa_out, pb_out); end total++;
    if (d_out !== '0 || d_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_bus got %h/%b want 0/0", d_out, d_oe); end total++;
    rst = 0;
    bus_rd(2'd3, v);
    if (v !== 8'h9B) begin bad++; $display("FAIL mid_rst_ctrl got %h want 9b", v); end total++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode0_random();
    test_a_in();
    test_a_out();
    test_b_collide();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
